// File: rtl/reg_file_wr_demux.sv
// ---------------------------------------------------------------------------
// reg_file_wr_demux
//
// 32 x 32-bit MIPS general-purpose register file for the single-cycle
// datapath. A 5-to-32 one-hot write decoder steers write-back data into
// exactly one register per clock. Two combinational read ports feed the
// ALU operand selectors. Register $0 reads as zero at all times.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; clears every register and
//                     write_onehot (wins over write_en)
//   write_en     in   RegWrite qualifier
//   write_addr   in   destination register index
//   write_data   in   write-back value
//   read_addr1   in   rs index
//   read_addr2   in   rt index
//   read_data1   out  register[read_addr1], combinational, no bypass
//   read_data2   out  register[read_addr2], combinational, no bypass
//   write_onehot out  registered decode of the write accepted at the
//                     previous edge (all zero if none / write to $0)
// ---------------------------------------------------------------------------
module reg_file_wr_demux #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   write_en,
   input  logic [ADDR_W-1:0]      write_addr,
   input  logic [WIDTH-1:0]       write_data,
   input  logic [ADDR_W-1:0]      read_addr1,
   input  logic [ADDR_W-1:0]      read_addr2,
   output logic [WIDTH-1:0]       read_data1,
   output logic [WIDTH-1:0]       read_data2,
   output logic [(2**ADDR_W)-1:0] write_onehot
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] onehot_d;
   logic [DEPTH-1:0] onehot_q;

   // Write decoder. Bit 0 is cleared after the decode so a write to $0
   // becomes a no-op and never shows up on write_onehot.
   always_comb begin
      onehot_d = '0;
      if (write_en) begin
         onehot_d[write_addr] = 1'b1;
      end
      onehot_d[0] = 1'b0;
   end

   // Next-state for the register array: only the decoded register loads.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         regs_d[k] = regs_q[k];
         if (onehot_d[k]) begin
            regs_d[k] = write_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
         onehot_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= regs_d[k];
         end
         onehot_q <= onehot_d;
      end
   end

   // Address 0 is forced to zero on the read side as well, so $0 reads as
   // zero even before the first reset has cleared the storage.
   always_comb begin
      read_data1 = regs_q[read_addr1];
      read_data2 = regs_q[read_addr2];
      if (read_addr1 == '0) begin
         read_data1 = '0;
      end
      if (read_addr2 == '0) begin
         read_data2 = '0;
      end
   end

   assign write_onehot = onehot_q;

endmodule
